// File: rtl/cv32e40p_err_aggregator.sv
// ----------------------------------------------------------------------------
// cv32e40p_err_aggregator
//
// Collects per-source error pulses (TMR mismatch, ECC, memory errors) into
// sticky status flags and per-source saturating event counters. It also
// captures the first recorded source and raises an interrupt through a small
// IDLE/ALERT/SERVICED state machine.
//
// Parameters
//   NUM_SRC  number of error sources (1..32)
//   CNT_W    width of each per-source event counter (2..16)
//   SEL_W    readout select / source index width, max(1, clog2(NUM_SRC))
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   err_i          per-source error pulses, one event per asserted cycle
//   mask_i         1 = ignore that source entirely
//   clr_i          single-cycle clear of status, counters, first capture, fatal
//   irq_ack_i      interrupt acknowledge
//   rd_sel_i       counter readout select
//   rd_cnt_o       counter of source rd_sel_i, 0 when out of range
//   status_o       sticky per-source error flags
//   first_valid_o  first-error capture valid
//   first_id_o     index of the first recorded source
//   irq_o          error interrupt request (asserted in ALERT)
//   fatal_o        sticky: some counter saturated
// ----------------------------------------------------------------------------
module cv32e40p_err_aggregator #(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 8,
    localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SRC-1:0] err_i,
    input  logic [NUM_SRC-1:0] mask_i,
    input  logic               clr_i,
    input  logic               irq_ack_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_cnt_o,
    output logic [NUM_SRC-1:0] status_o,
    output logic               first_valid_o,
    output logic [SEL_W-1:0]   first_id_o,
    output logic               irq_o,
    output logic               fatal_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALERT    = 2'd1,
        SERVICED = 2'd2
    } state_t;

    // Masked sources are invisible to every piece of state below.
    logic [NUM_SRC-1:0] eff;
    logic               eff_any;

    assign eff     = err_i & ~mask_i;
    assign eff_any = |eff;

    // ------------------------------------------------------------------------
    // Per-source saturating counters
    // ------------------------------------------------------------------------
    logic [NUM_SRC-1:0][CNT_W-1:0] cnt_all;
    logic [NUM_SRC-1:0]            sat_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            // A clear in the same cycle as an event restarts the count at 1,
            // so the event is not lost.
            always_comb begin
                cnt_next = cnt_reg;
                if (clr_i) begin
                    cnt_next = eff[gi] ? CNT_W'(1) : '0;
                end else if (eff[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign cnt_all[gi]  = cnt_reg;
            assign sat_next[gi] = (cnt_next == CNT_MAX);
        end
    endgenerate

    // Readout mux; out-of-range selects read as zero.
    always_comb begin
        rd_cnt_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(rd_sel_i) == i) begin
                rd_cnt_o = cnt_all[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status, fatal and first-error capture
    // ------------------------------------------------------------------------
    logic [NUM_SRC-1:0] status_reg, status_next;
    logic               fatal_reg, fatal_next;
    logic               first_valid_reg, first_valid_next;
    logic [SEL_W-1:0]   first_id_reg, first_id_next;
    logic [SEL_W-1:0]   lowest_id;

    // Lowest set index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        lowest_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eff[i]) begin
                lowest_id = SEL_W'(i);
            end
        end
    end

    always_comb begin
        logic             base_valid;
        logic [SEL_W-1:0] base_id;

        status_next = clr_i ? eff : (status_reg | eff);

        // Saturation can only be reached by counting, never right after a
        // clear (counter is then at most 1), so fatal restarts cleanly.
        fatal_next = (fatal_reg & ~clr_i) | (|sat_next);

        // Clear is applied first, then the current cycle may capture anew.
        base_valid = first_valid_reg & ~clr_i;
        base_id    = clr_i ? '0 : first_id_reg;
        if (!base_valid && eff_any) begin
            first_valid_next = 1'b1;
            first_id_next    = lowest_id;
        end else begin
            first_valid_next = base_valid;
            first_id_next    = base_id;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_reg      <= '0;
            fatal_reg       <= 1'b0;
            first_valid_reg <= 1'b0;
            first_id_reg    <= '0;
        end else begin
            status_reg      <= status_next;
            fatal_reg       <= fatal_next;
            first_valid_reg <= first_valid_next;
            first_id_reg    <= first_id_next;
        end
    end

    // ------------------------------------------------------------------------
    // Interrupt state machine
    // ------------------------------------------------------------------------
    state_t state_reg, state_next;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A new error always (re)enters ALERT, which takes priority over both
    // acknowledge and clear in the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (eff_any) begin
                    state_next = ALERT;
                end
            end
            ALERT: begin
                if (eff_any) begin
                    state_next = ALERT;
                end else if (irq_ack_i) begin
                    state_next = SERVICED;
                end else if (clr_i) begin
                    state_next = IDLE;
                end
            end
            SERVICED: begin
                if (eff_any) begin
                    state_next = ALERT;
                end else if (clr_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign irq_o         = (state_reg == ALERT);
    assign status_o      = status_reg;
    assign fatal_o       = fatal_reg;
    assign first_valid_o = first_valid_reg;
    assign first_id_o    = first_id_reg;

endmodule
